// File: rtl/cu_pkg.sv
// cu_pkg: shared definitions for the multi-cycle MIPS control unit.
// Holds the FSM state enum, the opcode constants decoded by the control
// unit and the encodings of the multi-bit datapath select outputs.
package cu_pkg;

   typedef enum logic [3:0] {
      StFetch    = 4'd0,
      StDecode   = 4'd1,
      StMemAdr   = 4'd2,
      StMemRead  = 4'd3,
      StMemWb    = 4'd4,
      StMemWrite = 4'd5,
      StExecute  = 4'd6,
      StRtypeWb  = 4'd7,
      StBranch   = 4'd8,
      StJump     = 4'd9,
      StImmEx    = 4'd10,
      StImmWb    = 4'd11,
      StJal      = 4'd12,
      StIllegal  = 4'd13,
      StBusErr   = 4'd14
   } cu_state_e;

   // Opcode field IR[31:26]
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   // ALUOp
   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;
   localparam logic [1:0] ALU_AND   = 2'b11;

   // PCSource
   localparam logic [1:0] PC_ALU    = 2'b00;
   localparam logic [1:0] PC_ALUOUT = 2'b01;
   localparam logic [1:0] PC_JUMP   = 2'b10;

   // MemtoReg
   localparam logic [1:0] M2R_ALUOUT = 2'b00;
   localparam logic [1:0] M2R_MDR    = 2'b01;
   localparam logic [1:0] M2R_PC     = 2'b10;

   // RegDst
   localparam logic [1:0] RDST_RT = 2'b00;
   localparam logic [1:0] RDST_RD = 2'b01;
   localparam logic [1:0] RDST_RA = 2'b10;

   // States that issue a memory access and wait for mem_ready
   function automatic logic is_mem_state(cu_state_e s);
      return (s == StFetch) || (s == StMemRead) || (s == StMemWrite);
   endfunction

endpackage

// File: rtl/cu_wait_timer.sv
// cu_wait_timer: counts not-ready cycles spent in a memory state and flags
// a timeout when the count has reached MAX_WAIT and memory is still not ready.
// Ports:
//   clk_i      clock
//   rst_ni     asynchronous active-low reset
//   clear_i    clear the count (FSM state is changing)
//   stall_i    current cycle is a memory state with mem_ready low
//   timeout_o  stall with the count already at MAX_WAIT
module cu_wait_timer #(
   parameter int unsigned MAX_WAIT = 15,
   parameter int unsigned WAIT_W   = 8
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clear_i,
   input  logic stall_i,
   output logic timeout_o
);

   logic [WAIT_W-1:0] cnt_d, cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (stall_i) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign timeout_o = stall_i && (cnt_q == WAIT_W'(MAX_WAIT));

endmodule

// File: rtl/cu_multicycle_ext.sv
// cu_multicycle_ext: Moore control FSM for the multi-cycle MIPS datapath.
// Sequences fetch/decode/execute/memory/writeback with a mem_ready handshake,
// a wait-state timeout into a terminal bus-error state, and illegal-opcode
// detection.
// Ports:
//   clk, reset (async, active-low), opcode = IR[31:26], zero = ALU zero flag,
//   mem_ready = memory access done this cycle.
//   Datapath controls: IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
//   RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, PCWrite_F.
//   Status: illegal_op (pulse), bus_error (sticky until reset).
module cu_multicycle_ext
   import cu_pkg::*;
#(
   parameter int unsigned MEM_HANDSHAKE = 1,
   parameter int unsigned MAX_WAIT      = 15,
   parameter int unsigned WAIT_W        = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] opcode,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       IorD,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic [1:0] MemtoReg,
   output logic [1:0] RegDst,
   output logic       RegWrite,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ALUOp,
   output logic [1:0] PCSource,
   output logic       PCWrite_F,
   output logic       illegal_op,
   output logic       bus_error
);

   cu_state_e state_d, state_q;
   logic      ready;
   logic      stall;
   logic      timeout;
   logic      pc_write;
   logic      pc_write_cond;
   logic      is_bne;

   assign ready  = (MEM_HANDSHAKE == 0) ? 1'b1 : mem_ready;
   assign stall  = is_mem_state(state_q) && !ready;
   assign is_bne = (opcode == OP_BNE);

   cu_wait_timer #(
      .MAX_WAIT (MAX_WAIT),
      .WAIT_W   (WAIT_W)
   ) u_wait_timer (
      .clk_i     (clk),
      .rst_ni    (reset),
      .clear_i   (state_d != state_q),
      .stall_i   (stall),
      .timeout_o (timeout)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StFetch;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         StFetch:    if (ready) state_d = StDecode;
         StDecode: begin
            case (opcode)
               OP_LW, OP_SW:     state_d = StMemAdr;
               OP_RTYPE:         state_d = StExecute;
               OP_BEQ, OP_BNE:   state_d = StBranch;
               OP_J:             state_d = StJump;
               OP_JAL:           state_d = StJal;
               OP_ADDI, OP_ANDI: state_d = StImmEx;
               default:          state_d = StIllegal;
            endcase
         end
         StMemAdr:   state_d = (opcode == OP_LW) ? StMemRead : StMemWrite;
         StMemRead:  if (ready) state_d = StMemWb;
         StMemWrite: if (ready) state_d = StFetch;
         StExecute:  state_d = StRtypeWb;
         StImmEx:    state_d = StImmWb;
         StMemWb, StRtypeWb, StImmWb, StBranch, StJump, StJal, StIllegal:
                     state_d = StFetch;
         StBusErr:   state_d = StBusErr;
         default:    state_d = StFetch;
      endcase
      // A ready in the same cycle as the limit wins; timeout already implies !ready
      if (timeout) state_d = StBusErr;
   end

   // Outputs
   always_comb begin
      IorD          = 1'b0;
      MemRead       = 1'b0;
      MemWrite      = 1'b0;
      IRWrite       = 1'b0;
      MemtoReg      = M2R_ALUOUT;
      RegDst        = RDST_RT;
      RegWrite      = 1'b0;
      ALUSrcA       = 1'b0;
      ALUSrcB       = 2'b00;
      ALUOp         = ALU_ADD;
      PCSource      = PC_ALU;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      illegal_op    = 1'b0;
      bus_error     = 1'b0;
      case (state_q)
         StFetch: begin
            MemRead  = 1'b1;
            ALUSrcB  = 2'b01;
            IRWrite  = ready;
            pc_write = ready;
         end
         StDecode:   ALUSrcB = 2'b11;
         StMemAdr: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
         end
         StMemRead: begin
            MemRead = 1'b1;
            IorD    = 1'b1;
         end
         StMemWrite: begin
            MemWrite = 1'b1;
            IorD     = 1'b1;
         end
         StMemWb: begin
            MemtoReg = M2R_MDR;
            RegWrite = 1'b1;
         end
         StExecute: begin
            ALUSrcA = 1'b1;
            ALUOp   = ALU_FUNCT;
         end
         StRtypeWb: begin
            RegDst   = RDST_RD;
            RegWrite = 1'b1;
         end
         StImmEx: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
            ALUOp   = (opcode == OP_ANDI) ? ALU_AND : ALU_ADD;
         end
         StImmWb:    RegWrite = 1'b1;
         StBranch: begin
            ALUSrcA       = 1'b1;
            ALUOp         = ALU_SUB;
            PCSource      = PC_ALUOUT;
            pc_write_cond = 1'b1;
         end
         StJump: begin
            PCSource = PC_JUMP;
            pc_write = 1'b1;
         end
         StJal: begin
            // Links the PC+4 already latched during fetch
            PCSource = PC_JUMP;
            pc_write = 1'b1;
            RegDst   = RDST_RA;
            MemtoReg = M2R_PC;
            RegWrite = 1'b1;
         end
         StIllegal:  illegal_op = 1'b1;
         StBusErr:   bus_error  = 1'b1;
         default:    ;
      endcase
      PCWrite_F = pc_write | (pc_write_cond & (zero ^ is_bne));
      // Reset kills every request immediately, not at the next edge
      if (!reset) begin
         IorD       = 1'b0;
         MemRead    = 1'b0;
         MemWrite   = 1'b0;
         IRWrite    = 1'b0;
         MemtoReg   = 2'b00;
         RegDst     = 2'b00;
         RegWrite   = 1'b0;
         ALUSrcA    = 1'b0;
         ALUSrcB    = 2'b00;
         ALUOp      = 2'b00;
         PCSource   = 2'b00;
         PCWrite_F  = 1'b0;
         illegal_op = 1'b0;
         bus_error  = 1'b0;
      end
   end

endmodule

// File: tb/tb_cu_multicycle_ext.sv
// tb_cu_multicycle_ext: scoreboard bench for cu_multicycle_ext (MAX_WAIT=4).
// Each cycle the expected output vector is queued as stimulus is applied and
// popped for comparison once the combinational outputs settle.
module tb_cu_multicycle_ext;

   localparam logic [5:0] LW = 6'h23, SW = 6'h2b, RT = 6'h00, BEQ = 6'h04, BNE = 6'h05;
   localparam logic [5:0] J = 6'h02, JAL = 6'h03, ADDI = 6'h08, ANDI = 6'h0c;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] opcode;
   logic       zero;
   logic       mem_ready;
   logic       IorD, MemRead, MemWrite, IRWrite, RegWrite, ALUSrcA, PCWrite_F;
   logic       illegal_op, bus_error;
   logic [1:0] MemtoReg, RegDst, ALUSrcB, ALUOp, PCSource;
   logic [18:0] act;

   int n_vec = 0;
   int n_err = 0;
   logic [18:0] sb_exp[$];
   string       sb_tag[$];

   always #5 clk = ~clk;

   cu_multicycle_ext #(
      .MEM_HANDSHAKE (1),
      .MAX_WAIT      (4),
      .WAIT_W        (8)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .opcode     (opcode),
      .zero       (zero),
      .mem_ready  (mem_ready),
      .IorD       (IorD),
      .MemRead    (MemRead),
      .MemWrite   (MemWrite),
      .IRWrite    (IRWrite),
      .MemtoReg   (MemtoReg),
      .RegDst     (RegDst),
      .RegWrite   (RegWrite),
      .ALUSrcA    (ALUSrcA),
      .ALUSrcB    (ALUSrcB),
      .ALUOp      (ALUOp),
      .PCSource   (PCSource),
      .PCWrite_F  (PCWrite_F),
      .illegal_op (illegal_op),
      .bus_error  (bus_error)
   );

   assign act = {IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA,
                 ALUSrcB, ALUOp, PCSource, PCWrite_F, illegal_op, bus_error};

   function automatic logic [18:0] ov(logic iord, logic mr, logic mw, logic irw,
                                      logic [1:0] m2r, logic [1:0] rdst, logic rw,
                                      logic srca, logic [1:0] srcb, logic [1:0] aluop,
                                      logic [1:0] pcs, logic pcw, logic ill, logic berr);
      return {iord, mr, mw, irw, m2r, rdst, rw, srca, srcb, aluop, pcs, pcw, ill, berr};
   endfunction

   function automatic logic [18:0] v_fetch(logic rdy);
      return ov(0, 1, 0, rdy, 2'b00, 2'b00, 0, 0, 2'b01, 2'b00, 2'b00, rdy, 0, 0);
   endfunction

   localparam logic [18:0] V_ZERO = 19'd0;

   task automatic check_eq(input string tag, input logic [18:0] got, input logic [18:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %05h expected %05h", tag, got, exp);
      end
   endtask

   // Apply one cycle of stimulus just after a negedge, compare, move to next negedge
   task automatic step(input string tag, input logic rdy, input logic [18:0] exp);
      mem_ready = rdy;
      sb_exp.push_back(exp);
      sb_tag.push_back(tag);
      #1;
      check_eq(sb_tag.pop_front(), act, sb_exp.pop_front());
      @(negedge clk);
   endtask

   function automatic logic rnd();
      return 1'($urandom_range(0, 1));
   endfunction

   task automatic run_instr(input logic [5:0] op, input logic z, input int fw, input int mw);
      logic pcw;
      opcode = op;
      zero   = z;
      for (int i = 0; i < fw; i++) step("fetch_wait", 1'b0, v_fetch(1'b0));
      step("fetch", 1'b1, v_fetch(1'b1));
      step("decode", rnd(), ov(0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 2'b11, 2'b00, 2'b00, 0, 0, 0));
      case (op)
         LW, SW: begin
            step("mem_adr", rnd(),
                 ov(0, 0, 0, 0, 2'b00, 2'b00, 0, 1, 2'b10, 2'b00, 2'b00, 0, 0, 0));
            if (op == LW) begin
               for (int i = 0; i <= mw; i++)
                  step("mem_read", (i == mw),
                       ov(1, 1, 0, 0, 2'b00, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0));
               step("mem_wb", rnd(),
                    ov(0, 0, 0, 0, 2'b01, 2'b00, 1, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0));
            end else begin
               for (int i = 0; i <= mw; i++)
                  step("mem_write", (i == mw),
                       ov(1, 0, 1, 0, 2'b00, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0));
            end
         end
         RT: begin
            step("execute", rnd(),
                 ov(0, 0, 0, 0, 2'b00, 2'b00, 0, 1, 2'b00, 2'b10, 2'b00, 0, 0, 0));
            step("rtype_wb", rnd(),
                 ov(0, 0, 0, 0, 2'b00, 2'b01, 1, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0));
         end
         ADDI, ANDI: begin
            step("imm_ex", rnd(), ov(0, 0, 0, 0, 2'b00, 2'b00, 0, 1, 2'b10,
                                     (op == ANDI) ? 2'b11 : 2'b00, 2'b00, 0, 0, 0));
            step("imm_wb", rnd(),
                 ov(0, 0, 0, 0, 2'b00, 2'b00, 1, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0));
         end
         BEQ, BNE: begin
            pcw = (op == BEQ) ? z : !z;
            step((op == BEQ) ? "beq" : "bne", rnd(),
                 ov(0, 0, 0, 0, 2'b00, 2'b00, 0, 1, 2'b00, 2'b01, 2'b01, pcw, 0, 0));
         end
         J:   step("jump", rnd(),
                   ov(0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 2'b00, 2'b00, 2'b10, 1, 0, 0));
         JAL: step("jal", rnd(),
                   ov(0, 0, 0, 0, 2'b10, 2'b10, 1, 0, 2'b00, 2'b00, 2'b10, 1, 0, 0));
         default:
              step("illegal", rnd(),
                   ov(0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 0, 1, 0));
      endcase
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      reset = 1'b0; opcode = RT; zero = 1'b0; mem_ready = 1'b0;
      @(negedge clk);
      step("reset_idle", 1'b0, V_ZERO);
      step("reset_rdy", 1'b1, V_ZERO);
      reset = 1'b1;

      run_instr(LW, 1'b0, 0, 0);
      run_instr(SW, 1'b1, 0, 3);
      run_instr(RT, 1'b0, 2, 0);
      run_instr(ADDI, 1'b0, 0, 0);
      run_instr(ANDI, 1'b1, 1, 0);
      run_instr(BEQ, 1'b0, 0, 0);
      run_instr(BEQ, 1'b1, 0, 0);
      run_instr(BNE, 1'b0, 0, 0);
      run_instr(BNE, 1'b1, 0, 0);
      run_instr(J, 1'b0, 0, 0);
      run_instr(JAL, 1'b1, 0, 0);
      run_instr(6'h3f, 1'b0, 0, 0);
      run_instr(6'h01, 1'b1, 0, 0);
      // Ready arriving exactly at the wait limit still proceeds
      run_instr(LW, 1'b0, 4, 4);
      run_instr(SW, 1'b0, 4, 4);

      // Reset during MEM_WRITE drops the write request in the same cycle
      opcode = SW;
      step("fetch", 1'b1, v_fetch(1'b1));
      step("decode", 1'b0, ov(0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 2'b11, 2'b00, 2'b00, 0, 0, 0));
      step("mem_adr", 1'b0, ov(0, 0, 0, 0, 2'b00, 2'b00, 0, 1, 2'b10, 2'b00, 2'b00, 0, 0, 0));
      mem_ready = 1'b0;
      #1;
      check_eq("mem_write_pre_rst", act,
               ov(1, 0, 1, 0, 2'b00, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0));
      reset = 1'b0;
      #1;
      check_eq("mem_write_rst", act, V_ZERO);
      @(negedge clk);
      reset = 1'b1;
      run_instr(RT, 1'b0, 0, 0);

      // Fetch stuck not-ready: five waiting cycles, then terminal BUS_ERR
      opcode = LW;
      for (int i = 0; i < 5; i++) step("fetch_stuck", 1'b0, v_fetch(1'b0));
      for (int i = 0; i < 4; i++)
         step("bus_err", rnd(), ov(0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 1));
      reset = 1'b0;
      #1;
      check_eq("bus_err_rst", act, V_ZERO);
      @(negedge clk);
      reset = 1'b1;
      run_instr(LW, 1'b1, 1, 2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
